// File: rtl/receiver_framer.sv
// Serial-to-word framer feeding receiver_memory: start bit, MSB-first data, optional even
// parity, stop bit. Good words are written at an auto-incrementing, wrapping address.
module receiver_framer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SerialIn,
    input  logic                  BitValid,
    input  logic                  Clear,
    output logic [DATA_WIDTH-1:0] MemDataIn,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemWriteEnable,
    output logic [ADDR_WIDTH:0]   WordCount,
    output logic                  Full,
    output logic                  FrameError,
    output logic                  Overflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WRITE} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic                  parity_bit, parity_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  we_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  full_next;
    logic                  fe_next;
    logic                  ov_next;
    logic                  frame_good;

    // Even parity: data and parity bit together must hold an even number of ones.
    assign frame_good = SerialIn && ((PARITY_EN == 0) || !(^{shift_reg, parity_bit}));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        data_next    = MemDataIn;
        addr_next    = MemAddress;
        we_next      = 1'b0;
        count_next   = WordCount;
        full_next    = Full;
        fe_next      = 1'b0;
        ov_next      = 1'b0;

        if (Clear) begin
            state_next   = IDLE;
            shift_next   = '0;
            bit_cnt_next = '0;
            parity_next  = 1'b0;
            addr_next    = '0;
            count_next   = '0;
            full_next    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (BitValid && !SerialIn) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                        shift_next   = '0;
                    end
                end
                DATA: begin
                    if (BitValid) begin
                        shift_next   = {shift_reg[DATA_WIDTH-2:0], SerialIn};
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1))
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (BitValid) begin
                        parity_next = SerialIn;
                        state_next  = STOP;
                    end
                end
                STOP: begin
                    if (BitValid) begin
                        state_next = IDLE;
                        if (!frame_good) begin
                            fe_next = 1'b1;
                        end else if (Full) begin
                            ov_next = 1'b1;
                        end else begin
                            data_next  = shift_reg;
                            we_next    = 1'b1;
                            state_next = WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Only entered when not Full, so the count cannot pass DEPTH.
                    state_next = IDLE;
                    addr_next  = MemAddress + ADDR_WIDTH'(1);
                    count_next = WordCount + (ADDR_WIDTH + 1)'(1);
                    full_next  = (WordCount == (ADDR_WIDTH + 1)'(DEPTH - 1));
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            parity_bit     <= 1'b0;
            MemDataIn      <= '0;
            MemAddress     <= '0;
            MemWriteEnable <= 1'b0;
            WordCount      <= '0;
            Full           <= 1'b0;
            FrameError     <= 1'b0;
            Overflow       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state          <= state_next;
            shift_reg      <= shift_next;
            bit_cnt        <= bit_cnt_next;
            parity_bit     <= parity_next;
            MemDataIn      <= data_next;
            MemAddress     <= addr_next;
            MemWriteEnable <= we_next;
            WordCount      <= count_next;
            Full           <= full_next;
            FrameError     <= fe_next;
            Overflow       <= ov_next;
        end
    end

endmodule

// File: tb/tb_receiver_framer.sv
// Directed self-checking bench for receiver_framer: table of single frames plus
// hand-written sequences for fill/overflow, Clear mid-frame and reset mid-frame.
module tb_receiver_framer;

    logic        clk;
    logic        rst_n;
    logic        SerialIn;
    logic        BitValid;
    logic        Clear;
    logic [15:0] MemDataIn;
    logic [3:0]  MemAddress;
    logic        MemWriteEnable;
    logic [4:0]  WordCount;
    logic        Full;
    logic        FrameError;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    int          we_seen = 0;
    int          fe_seen = 0;
    int          ov_seen = 0;
    logic [3:0]  last_addr = '0;
    logic [15:0] last_data = '0;

    receiver_framer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .SerialIn       (SerialIn),
        .BitValid       (BitValid),
        .Clear          (Clear),
        .MemDataIn      (MemDataIn),
        .MemAddress     (MemAddress),
        .MemWriteEnable (MemWriteEnable),
        .WordCount      (WordCount),
        .Full           (Full),
        .FrameError     (FrameError),
        .Overflow       (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs change on posedge; observe them on negedge.
    always @(negedge clk) begin
        if (MemWriteEnable) begin
            we_seen   <= we_seen + 1;
            last_addr <= MemAddress;
            last_data <= MemDataIn;
        end
        if (FrameError) fe_seen <= fe_seen + 1;
        if (Overflow)   ov_seen <= ov_seen + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        SerialIn = b;
        BitValid = 1'b1;
        @(negedge clk);
        BitValid = 1'b0;
        SerialIn = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 15; i >= 0; i--) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] data;
        logic        par_bad;
        logic        stop;
        int          exp_we;
        int          exp_fe;
        logic [3:0]  exp_waddr;
        logic [3:0]  exp_addr;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int we0, fe0, ov0;

        vecs[0] = '{16'hABCD, 1'b0, 1'b1, 1, 0, 4'd0, 4'd1, 5'd1};
        vecs[1] = '{16'h1234, 1'b1, 1'b1, 0, 1, 4'd0, 4'd1, 5'd1};
        vecs[2] = '{16'h0001, 1'b0, 1'b0, 0, 1, 4'd0, 4'd1, 5'd1};
        vecs[3] = '{16'h0002, 1'b0, 1'b1, 1, 0, 4'd1, 4'd2, 5'd2};
        vecs[4] = '{16'hFFFF, 1'b1, 1'b0, 0, 1, 4'd0, 4'd2, 5'd2};
        vecs[5] = '{16'h8000, 1'b0, 1'b1, 1, 0, 4'd2, 4'd3, 5'd3};

        rst_n    = 1'b0;
        SerialIn = 1'b1;
        BitValid = 1'b0;
        Clear    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset MemDataIn", 32'(MemDataIn), 32'h0);
        check("reset MemAddress", 32'(MemAddress), 32'h0);
        check("reset MemWriteEnable", 32'(MemWriteEnable), 32'h0);
        check("reset WordCount", 32'(WordCount), 32'h0);
        check("reset flags", {29'h0, Full, FrameError, Overflow}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames; correct even parity is the XOR of the data bits.
        for (int v = 0; v < 6; v++) begin
            we0 = we_seen; fe0 = fe_seen; ov0 = ov_seen;
            send_frame(vecs[v].data, (^vecs[v].data) ^ vecs[v].par_bad, vecs[v].stop);
            check($sformatf("vec%0d we pulses", v), 32'(we_seen - we0), 32'(vecs[v].exp_we));
            check($sformatf("vec%0d fe pulses", v), 32'(fe_seen - fe0), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d ov pulses", v), 32'(ov_seen - ov0), 32'h0);
            check($sformatf("vec%0d MemAddress", v), 32'(MemAddress), 32'(vecs[v].exp_addr));
            check($sformatf("vec%0d WordCount", v), 32'(WordCount), 32'(vecs[v].exp_count));
            if (vecs[v].exp_we != 0) begin
                check($sformatf("vec%0d write addr", v), 32'(last_addr), 32'(vecs[v].exp_waddr));
                check($sformatf("vec%0d write data", v), 32'(last_data), 32'(vecs[v].data));
            end
        end

        // Fill all 16 slots from a cleared state, then overflow.
        @(negedge clk); Clear = 1'b1;
        @(negedge clk); Clear = 1'b0;
        check("clear MemAddress", 32'(MemAddress), 32'h0);
        check("clear WordCount", 32'(WordCount), 32'h0);
        for (int i = 0; i < 16; i++) begin
            we0 = we_seen;
            send_frame(16'(i), ^(16'(i)), 1'b1);
            check($sformatf("fill%0d we pulses", i), 32'(we_seen - we0), 32'h1);
            check($sformatf("fill%0d write addr", i), 32'(last_addr), 32'(i));
            check($sformatf("fill%0d write data", i), 32'(last_data), 32'(i));
            check($sformatf("fill%0d Full", i), 32'(Full), (i == 15) ? 32'h1 : 32'h0);
        end
        check("fill MemAddress wrap", 32'(MemAddress), 32'h0);
        check("fill WordCount", 32'(WordCount), 32'd16);
        we0 = we_seen; ov0 = ov_seen;
        send_frame(16'hFFFF, 1'b0, 1'b1);
        check("overflow pulses", 32'(ov_seen - ov0), 32'h1);
        check("overflow no write", 32'(we_seen - we0), 32'h0);
        check("overflow WordCount", 32'(WordCount), 32'd16);
        check("overflow Full held", 32'(Full), 32'h1);
        check("overflow MemDataIn held", 32'(MemDataIn), 32'h000F);

        // Clear after 8 data bits; trailing ones must not start a frame.
        we0 = we_seen; fe0 = fe_seen;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        @(negedge clk); Clear = 1'b1;
        @(negedge clk); Clear = 1'b0;
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        repeat (3) @(negedge clk);
        check("midclear no write", 32'(we_seen - we0), 32'h0);
        check("midclear no error", 32'(fe_seen - fe0), 32'h0);
        check("midclear MemAddress", 32'(MemAddress), 32'h0);
        check("midclear WordCount", 32'(WordCount), 32'h0);
        check("midclear Full", 32'(Full), 32'h0);
        send_frame(16'h00A5, ^(16'h00A5), 1'b1);
        check("postclear write addr", 32'(last_addr), 32'h0);
        check("postclear MemAddress", 32'(MemAddress), 32'h1);

        // Reset for one cycle in the middle of DATA.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midreset MemDataIn", 32'(MemDataIn), 32'h0);
        check("midreset MemAddress", 32'(MemAddress), 32'h0);
        check("midreset WordCount", 32'(WordCount), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        we0 = we_seen;
        send_frame(16'h5A5A, ^(16'h5A5A), 1'b1);
        check("postreset we pulses", 32'(we_seen - we0), 32'h1);
        check("postreset write addr", 32'(last_addr), 32'h0);
        check("postreset write data", 32'(last_data), 32'h5A5A);
        check("postreset WordCount", 32'(WordCount), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
